mem_burst_arbiter: RTL and testbench
====================================

// Module: mem_burst_arbiter
// PURPOSE
//  Shares one memory-controller burst port (rd_*/wr_* valid/ready/finish style) among NUM_REQ masters.
//  Masters are the video input writers, image processing and the HDMI frame reader.
//  Round-robin arbitration, one burst in flight at a time; read and write bursts are serialised.
//  Sits between the masters and the DDR controller user port.
// PARAMETERS
//  NUM_REQ      4   number of masters (2..8)
//  MEM_DATA_LEN 64  data beat width
//  ADDR_LEN     32  burst start address width
//  LEN_W        10  burst length width
// PORTS
//  clk              in   1                    memory clock
//  rst              in   1                    async reset, active low
//  s_rd_valid       in   NUM_REQ              per-master read request, held until its finish
//  s_rd_burst_len   in   NUM_REQ*LEN_W        flattened, master i at [i*LEN_W +: LEN_W]
//  s_rd_addr        in   NUM_REQ*ADDR_LEN     flattened read start addresses
//  s_rd_ready       out  NUM_REQ              m_rd_ready gated to granted master
//  s_rd_data        out  MEM_DATA_LEN         m_rd_data broadcast to all masters
//  s_rd_burst_finish out NUM_REQ              m_rd_burst_finish gated to granted master
//  s_wr_valid       in   NUM_REQ              per-master write request
//  s_wr_burst_len   in   NUM_REQ*LEN_W        flattened
//  s_wr_addr        in   NUM_REQ*ADDR_LEN     flattened
//  s_wr_data        in   NUM_REQ*MEM_DATA_LEN flattened write beats
//  s_wr_ready       out  NUM_REQ              m_wr_ready gated to granted master
//  s_wr_burst_finish out NUM_REQ              gated
//  m_rd_valid / m_rd_burst_len / m_rd_addr          out  1/LEN_W/ADDR_LEN  to controller
//  m_rd_ready / m_rd_data / m_rd_burst_finish       in   1/MEM_DATA_LEN/1
//  m_wr_valid / m_wr_burst_len / m_wr_addr / m_wr_data  out  1/LEN_W/ADDR_LEN/MEM_DATA_LEN
//  m_wr_ready / m_wr_burst_finish                   in   1/1
//  grant_id         out  $clog2(NUM_REQ)      current or last granted master
//  busy             out  1                    high while a burst is granted
//  error            out  1                    sticky protocol error
// BEHAVIOUR
//  Reset: all m_* valid/len/addr = 0, grant_id = 0, busy = 0, error = 0, state = IDLE, rr_ptr = NUM_REQ-1 (master 0 wins first).
//  FSM IDLE -> RD | WR -> GAP -> IDLE.
//  IDLE:
//   - req[i] = s_rd_valid[i] | s_wr_valid[i].
//   - Winner is the first set bit searching from rr_ptr+1 upward, wrapping at NUM_REQ.
//   - On a win, in the same edge:
//     - latch grant_id and rr_ptr <= winner;
//     - register the winner's addr/len onto m_*;
//     - set m_rd_valid (if s_rd_valid[winner]) else m_wr_valid.
//   - A master requesting both read and write gets its read first; its write is served at its next grant.
//   - Grant latency: 1 clk from request seen in IDLE to m_*_valid high.
//  RD: m_rd_valid held.
//   - s_rd_ready[grant_id] = m_rd_ready combinationally; other bits 0.
//   - s_rd_data = m_rd_data, ungated.
//   - On m_rd_burst_finish: s_rd_burst_finish[grant_id] pulses in the same cycle; m_rd_valid <= 0; go to GAP.
//  WR: same as RD on the write side.
//   - m_wr_data = s_wr_data[grant_id] combinationally, so beats stream with 0 added latency.
//   - m_wr_burst_len/addr stay registered for the whole burst.
//  GAP: exactly 1 clk, requests ignored. This covers masters that drop valid one clk after finish. Then IDLE.
//  Minimum spacing between bursts: finish -> next m_*_valid = 3 clk (GAP, IDLE, valid).
//  busy = (state == RD || state == WR).
//  Error (sticky, set to 1; cleared only by rst) when any of these occur:
//   - m_*_burst_finish arrives outside RD/WR, or on the opposite channel;
//   - the granted master drops its valid before finish. The burst still completes normally.
//  Finish and a new request in the same cycle: the request waits through GAP. No burst is lost.
//  Reset mid-burst: the outputs return to reset values immediately. The controller is reset on the same rst.
// CONFIGURATION
//  Macro MEM_ARB_PRIORITY_EN.
//   - Defined: master 0 (HDMI reader) has fixed top priority. It wins in IDLE whenever req[0]=1 and does not advance rr_ptr.
//     The remaining masters share round-robin.
//   - Undefined: pure round-robin over all masters.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE, RD, WR, GAP) as localparams; function for ID width clog2.
//  Sub-module rr_pick:
//   - combinational round-robin picker;
//   - inputs req[NUM_REQ], ptr; outputs hit, idx;
//   - the priority override is handled in the parent under the macro.
//  Parent holds the FSM, the registered command mux, the ready/finish demux and the write-data mux.
// TESTING
//  1. Single master 2 requests rd 0x1000 len 1:
//     - m_rd_valid rises 1 clk later with addr 0x1000;
//     - m_rd_burst_finish -> s_rd_burst_finish[2] pulses in the same clk; other bits stay 0.
//  2. Masters 0..3 all assert wr after reset:
//     - grants go 0,1,2,3,0 in order;
//     - m_wr_data equals each granted master's data pattern;
//     - no valid for 2 clk after each finish.
//  3. Master 1 holds rd and wr valid:
//     - rd granted first;
//     - with master 3 also pending wr, the order is 1rd, 3wr, 1wr.
//  4. Master 1 drops s_rd_valid mid-burst: error = 1 and stays 1; the burst completes; arbitration continues.
//  5. Reset mid-WR burst: all m_* = 0 and busy = 0 within the same clk; after release master 0 wins first.
//  6. With MEM_ARB_PRIORITY_EN, master 0 re-requesting after every burst: masters 1..3 are served only in clk windows where req[0] = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Package : mem_arb_pkg
// Shared arbiter state encoding and ID-width helper for mem_burst_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_burst_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Combinational round-robin picker: first set request after ptr, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               hit,
  output logic [ID_W-1:0]    idx
);

  // Scan farthest-first so the closest candidate after ptr is the last write.
  always_comb begin
    logic [ID_W-1:0] w_cand;
    hit    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[w_cand]) begin
        hit = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
// ============================================================================
// Module  : mem_burst_arbiter
// Round-robin share of one DDR burst port among NUM_REQ masters, one burst at
// a time. Optional macro MEM_ARB_PRIORITY_EN gives master 0 fixed top priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MEM_DATA_LEN = 64,
  parameter int ADDR_LEN     = 32,
  parameter int LEN_W        = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               s_rd_valid,
  input  logic [NUM_REQ*LEN_W-1:0]         s_rd_burst_len,
  input  logic [NUM_REQ*ADDR_LEN-1:0]      s_rd_addr,
  output logic [NUM_REQ-1:0]               s_rd_ready,
  output logic [MEM_DATA_LEN-1:0]          s_rd_data,
  output logic [NUM_REQ-1:0]               s_rd_burst_finish,
  input  logic [NUM_REQ-1:0]               s_wr_valid,
  input  logic [NUM_REQ*LEN_W-1:0]         s_wr_burst_len,
  input  logic [NUM_REQ*ADDR_LEN-1:0]      s_wr_addr,
  input  logic [NUM_REQ*MEM_DATA_LEN-1:0]  s_wr_data,
  output logic [NUM_REQ-1:0]               s_wr_ready,
  output logic [NUM_REQ-1:0]               s_wr_burst_finish,
  output logic                             m_rd_valid,
  output logic [LEN_W-1:0]                 m_rd_burst_len,
  output logic [ADDR_LEN-1:0]              m_rd_addr,
  input  logic                             m_rd_ready,
  input  logic [MEM_DATA_LEN-1:0]          m_rd_data,
  input  logic                             m_rd_burst_finish,
  output logic                             m_wr_valid,
  output logic [LEN_W-1:0]                 m_wr_burst_len,
  output logic [ADDR_LEN-1:0]              m_wr_addr,
  output logic [MEM_DATA_LEN-1:0]          m_wr_data,
  input  logic                             m_wr_ready,
  input  logic                             m_wr_burst_finish,
  output logic [id_width(NUM_REQ)-1:0]     grant_id,
  output logic                             busy,
  output logic                             error
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_m_rd_valid;
  logic                  r_m_wr_valid;
  logic [LEN_W-1:0]      r_m_rd_len;
  logic [LEN_W-1:0]      r_m_wr_len;
  logic [ADDR_LEN-1:0]   r_m_rd_addr;
  logic [ADDR_LEN-1:0]   r_m_wr_addr;
  logic                  r_error;

  logic [NUM_REQ-1:0]    w_req;
  logic                  w_pick_hit;
  logic [ID_W-1:0]       w_pick_idx;
  logic                  w_win_hit;
  logic [ID_W-1:0]       w_win_idx;
  logic                  w_adv_ptr;
  logic                  w_grant;
  logic                  w_err_evt;

  logic [ADDR_LEN-1:0]     w_rd_addr [NUM_REQ];
  logic [ADDR_LEN-1:0]     w_wr_addr [NUM_REQ];
  logic [LEN_W-1:0]        w_rd_len  [NUM_REQ];
  logic [LEN_W-1:0]        w_wr_len  [NUM_REQ];
  logic [MEM_DATA_LEN-1:0] w_wr_dat  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_rd_addr[gi] = s_rd_addr[gi*ADDR_LEN +: ADDR_LEN];
    assign w_wr_addr[gi] = s_wr_addr[gi*ADDR_LEN +: ADDR_LEN];
    assign w_rd_len[gi]  = s_rd_burst_len[gi*LEN_W +: LEN_W];
    assign w_wr_len[gi]  = s_wr_burst_len[gi*LEN_W +: LEN_W];
    assign w_wr_dat[gi]  = s_wr_data[gi*MEM_DATA_LEN +: MEM_DATA_LEN];
  end

  assign w_req = s_rd_valid | s_wr_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req (w_req),
    .ptr (r_rr_ptr),
    .hit (w_pick_hit),
    .idx (w_pick_idx)
  );

`ifdef MEM_ARB_PRIORITY_EN
  // Master 0 overrides the rotation and leaves the pointer where it was.
  assign w_win_hit = w_pick_hit;
  assign w_win_idx = w_req[0] ? '0 : w_pick_idx;
  assign w_adv_ptr = ~w_req[0];
`else
  assign w_win_hit = w_pick_hit;
  assign w_win_idx = w_pick_idx;
  assign w_adv_ptr = 1'b1;
`endif

  assign w_grant = (r_state == ST_IDLE) && w_win_hit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_win_hit) w_state_nxt = s_rd_valid[w_win_idx] ? ST_RD : ST_WR;
      ST_RD:   if (m_rd_burst_finish) w_state_nxt = ST_GAP;
      ST_WR:   if (m_wr_burst_finish) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_m_rd_valid <= 1'b0;
      r_m_wr_valid <= 1'b0;
      r_m_rd_len   <= '0;
      r_m_wr_len   <= '0;
      r_m_rd_addr  <= '0;
      r_m_wr_addr  <= '0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_win_idx;
        if (w_adv_ptr) r_rr_ptr <= w_win_idx;
        if (s_rd_valid[w_win_idx]) begin
          r_m_rd_valid <= 1'b1;
          r_m_rd_addr  <= w_rd_addr[w_win_idx];
          r_m_rd_len   <= w_rd_len[w_win_idx];
        end else begin
          r_m_wr_valid <= 1'b1;
          r_m_wr_addr  <= w_wr_addr[w_win_idx];
          r_m_wr_len   <= w_wr_len[w_win_idx];
        end
      end
      if ((r_state == ST_RD) && m_rd_burst_finish) r_m_rd_valid <= 1'b0;
      if ((r_state == ST_WR) && m_wr_burst_finish) r_m_wr_valid <= 1'b0;
    end
  end

  // Stray or cross-channel finishes and early valid drops are all sticky.
  assign w_err_evt = (m_rd_burst_finish && (r_state != ST_RD)) ||
                     (m_wr_burst_finish && (r_state != ST_WR)) ||
                     ((r_state == ST_RD) && !s_rd_valid[r_grant_id]) ||
                     ((r_state == ST_WR) && !s_wr_valid[r_grant_id]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_error <= 1'b0;
    else if (w_err_evt) r_error <= 1'b1;
  end

  always_comb begin
    s_rd_ready        = '0;
    s_rd_burst_finish = '0;
    s_wr_ready        = '0;
    s_wr_burst_finish = '0;
    m_wr_data         = '0;
    if (r_state == ST_RD) begin
      s_rd_ready[r_grant_id]        = m_rd_ready;
      s_rd_burst_finish[r_grant_id] = m_rd_burst_finish;
    end
    if (r_state == ST_WR) begin
      s_wr_ready[r_grant_id]        = m_wr_ready;
      s_wr_burst_finish[r_grant_id] = m_wr_burst_finish;
      m_wr_data                     = w_wr_dat[r_grant_id];
    end
  end

  assign s_rd_data      = m_rd_data;
  assign m_rd_valid     = r_m_rd_valid;
  assign m_rd_burst_len = r_m_rd_len;
  assign m_rd_addr      = r_m_rd_addr;
  assign m_wr_valid     = r_m_wr_valid;
  assign m_wr_burst_len = r_m_wr_len;
  assign m_wr_addr      = r_m_wr_addr;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state == ST_RD) || (r_state == ST_WR);
  assign error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_arbiter.sv
// ============================================================================
// Module  : tb_mem_burst_arbiter
// Self-checking bench: bench-side controller and masters, cycle model, directed tests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    s_rd_valid = '0;
  logic [N*LW-1:0] s_rd_burst_len = '0;
  logic [N*AW-1:0] s_rd_addr = '0;
  logic [N-1:0]    s_rd_ready;
  logic [DW-1:0]   s_rd_data;
  logic [N-1:0]    s_rd_burst_finish;
  logic [N-1:0]    s_wr_valid = '0;
  logic [N*LW-1:0] s_wr_burst_len = '0;
  logic [N*AW-1:0] s_wr_addr = '0;
  logic [N*DW-1:0] s_wr_data = '0;
  logic [N-1:0]    s_wr_ready;
  logic [N-1:0]    s_wr_burst_finish;
  logic            m_rd_valid;
  logic [LW-1:0]   m_rd_burst_len;
  logic [AW-1:0]   m_rd_addr;
  logic            m_rd_ready = 1'b0;
  logic [DW-1:0]   m_rd_data = '0;
  logic            m_rd_burst_finish = 1'b0;
  logic            m_wr_valid;
  logic [LW-1:0]   m_wr_burst_len;
  logic [AW-1:0]   m_wr_addr;
  logic [DW-1:0]   m_wr_data;
  logic            m_wr_ready = 1'b0;
  logic            m_wr_burst_finish = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            error;

  mem_burst_arbiter #(.NUM_REQ(N), .MEM_DATA_LEN(DW), .ADDR_LEN(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .s_rd_valid(s_rd_valid), .s_rd_burst_len(s_rd_burst_len), .s_rd_addr(s_rd_addr),
    .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data), .s_rd_burst_finish(s_rd_burst_finish),
    .s_wr_valid(s_wr_valid), .s_wr_burst_len(s_wr_burst_len), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .s_wr_ready(s_wr_ready), .s_wr_burst_finish(s_wr_burst_finish),
    .m_rd_valid(m_rd_valid), .m_rd_burst_len(m_rd_burst_len), .m_rd_addr(m_rd_addr),
    .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data), .m_rd_burst_finish(m_rd_burst_finish),
    .m_wr_valid(m_wr_valid), .m_wr_burst_len(m_wr_burst_len), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready), .m_wr_burst_finish(m_wr_burst_finish),
    .grant_id(grant_id), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          md_inflight = 1'b0;
  bit          md_rd       = 1'b0;
  int          md_cur      = 0;
  int          md_grant    = 0;
  int          md_last     = N - 1;
  int          md_hold     = 0;
  bit          md_err      = 1'b0;
  logic [AW-1:0] md_addr   = '0;
  logic [LW-1:0] md_len    = '0;

  always @(posedge clk) begin
    int w;
    int j;
    if (!rst) begin
      md_inflight = 1'b0; md_rd = 1'b0; md_cur = 0; md_grant = 0;
      md_last = N - 1; md_hold = 0; md_err = 1'b0;
    end else begin
      if (m_rd_burst_finish && !(md_inflight && md_rd))  md_err = 1'b1;
      if (m_wr_burst_finish && !(md_inflight && !md_rd)) md_err = 1'b1;
      if (md_inflight && md_rd && !s_rd_valid[md_cur])   md_err = 1'b1;
      if (md_inflight && !md_rd && !s_wr_valid[md_cur])  md_err = 1'b1;
      if (md_inflight) begin
        if (md_rd ? m_rd_burst_finish : m_wr_burst_finish) begin
          md_inflight = 1'b0;
          md_hold     = 1;
        end
      end else if (md_hold > 0) begin
        md_hold--;
      end else begin
        w = -1;
`ifdef MEM_ARB_PRIORITY_EN
        if (s_rd_valid[0] || s_wr_valid[0]) w = 0;
`endif
        for (int k = 1; k <= N; k++) begin
          j = (md_last + k) % N;
          if (w < 0 && (s_rd_valid[j] || s_wr_valid[j])) w = j;
        end
        if (w >= 0) begin
          md_inflight = 1'b1;
          md_cur      = w;
          md_grant    = w;
          md_rd       = s_rd_valid[w];
          md_addr     = md_rd ? s_rd_addr[w*AW +: AW] : s_wr_addr[w*AW +: AW];
          md_len      = md_rd ? s_rd_burst_len[w*LW +: LW] : s_wr_burst_len[w*LW +: LW];
`ifdef MEM_ARB_PRIORITY_EN
          if (w != 0) md_last = w;
`else
          md_last = w;
`endif
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int   cyc = 0;
  int   fin_cyc = -100;
  int   min_gap = 999;
  bit   prev_v = 1'b0;
  int   log_id[$];
  bit   log_rd[$];
  logic [N-1:0]  e_rr, e_rf, e_wr, e_wf;
  logic [DW-1:0] e_wd;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_m_rd_valid", m_rd_valid, 0);
      chk("rst_m_wr_valid", m_wr_valid, 0);
      chk("rst_m_rd_addr", m_rd_addr, 0);
      chk("rst_m_wr_addr", m_wr_addr, 0);
      chk("rst_m_wr_data", m_wr_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      prev_v = 1'b0;
    end else begin
      e_rr = '0; e_rf = '0; e_wr = '0; e_wf = '0; e_wd = '0;
      if (md_inflight && md_rd) begin
        e_rr[md_cur] = m_rd_ready;
        e_rf[md_cur] = m_rd_burst_finish;
      end
      if (md_inflight && !md_rd) begin
        e_wr[md_cur] = m_wr_ready;
        e_wf[md_cur] = m_wr_burst_finish;
        e_wd = s_wr_data[md_cur*DW +: DW];
      end
      chk("m_rd_valid", m_rd_valid, md_inflight && md_rd);
      chk("m_wr_valid", m_wr_valid, md_inflight && !md_rd);
      chk("busy", busy, md_inflight);
      chk("grant_id", grant_id, md_grant);
      chk("error", error, md_err);
      chk("s_rd_ready", s_rd_ready, e_rr);
      chk("s_rd_burst_finish", s_rd_burst_finish, e_rf);
      chk("s_wr_ready", s_wr_ready, e_wr);
      chk("s_wr_burst_finish", s_wr_burst_finish, e_wf);
      chk("m_wr_data", m_wr_data, e_wd);
      chk("s_rd_data", s_rd_data, m_rd_data);
      if (md_inflight && md_rd) begin
        chk("m_rd_addr", m_rd_addr, md_addr);
        chk("m_rd_burst_len", m_rd_burst_len, md_len);
      end
      if (md_inflight && !md_rd) begin
        chk("m_wr_addr", m_wr_addr, md_addr);
        chk("m_wr_burst_len", m_wr_burst_len, md_len);
      end
      if (m_rd_burst_finish || m_wr_burst_finish) fin_cyc = cyc;
      if ((m_rd_valid || m_wr_valid) && !prev_v) begin
        log_id.push_back(int'(grant_id));
        log_rd.push_back(m_rd_valid);
        if (cyc - fin_cyc < min_gap) min_gap = cyc - fin_cyc;
      end
      prev_v = m_rd_valid || m_wr_valid;
    end
  end

  // ---------------- bench-side masters and controller ----------------
  logic [N-1:0] rearm_rd = '0;
  logic [N-1:0] rearm_wr = '0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic step();
    logic [N-1:0] fr, fw, t;
    @(negedge clk);
    fr = s_rd_burst_finish;
    fw = s_wr_burst_finish;
    @(posedge clk);
    #2;
    t = s_rd_valid; s_rd_valid = (t & ~fr) | (rearm_rd & ~t);
    t = s_wr_valid; s_wr_valid = (t & ~fw) | (rearm_wr & ~t);
    m_rd_ready = 1'b0; m_rd_burst_finish = 1'b0;
    m_wr_ready = 1'b0; m_wr_burst_finish = 1'b0;
    m_rd_data  = {$urandom(), $urandom()};
    if (rst && m_rd_valid) begin
      if (rd_cnt < int'(m_rd_burst_len)) begin m_rd_ready = 1'b1; rd_cnt++; end
      else begin m_rd_burst_finish = 1'b1; rd_cnt = 0; end
    end
    if (rst && m_wr_valid) begin
      if (wr_cnt < int'(m_wr_burst_len)) begin m_wr_ready = 1'b1; wr_cnt++; end
      else begin m_wr_burst_finish = 1'b1; wr_cnt = 0; end
    end
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a, input int len);
    s_rd_addr[i*AW +: AW]      = a;
    s_rd_burst_len[i*LW +: LW] = LW'(len);
    s_rd_valid[i]              = 1'b1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input int len);
    s_wr_addr[i*AW +: AW]      = a;
    s_wr_burst_len[i*LW +: LW] = LW'(len);
    s_wr_valid[i]              = 1'b1;
  endtask

  task automatic clear_inputs();
    s_rd_valid = '0; s_wr_valid = '0; rearm_rd = '0; rearm_wr = '0;
    m_rd_ready = 1'b0; m_rd_burst_finish = 1'b0;
    m_wr_ready = 1'b0; m_wr_burst_finish = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step(); step();
    rst = 1'b1;
  endtask

  task automatic wait_grant(input int max);
    int n = 0;
    while (!(m_rd_valid || m_wr_valid) && n < max) begin step(); n++; end
    chk("grant_within_bound", m_rd_valid || m_wr_valid, 1);
  endtask

  task automatic wait_fin(input int max);
    int n = 0;
    while (!(m_rd_burst_finish || m_wr_burst_finish) && n < max) begin step(); n++; end
    chk("finish_within_bound", m_rd_burst_finish || m_wr_burst_finish, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || (|s_rd_valid) || (|s_wr_valid)) && n < max) begin
      step(); n++;
      if (log_id.size() >= 3) rearm_rd = '0;
    end
    chk("idle_within_bound", busy || (|s_rd_valid) || (|s_wr_valid), 0);
    step(); step(); step();
  endtask

  logic [DW-1:0] c_pat [N] = '{64'h1111_2222_3333_0000, 64'hAAAA_BBBB_CCCC_0001,
                               64'h5A5A_A5A5_0F0F_0002, 64'hDEAD_BEEF_CAFE_0003};
  int c_ord2 [5] = '{0, 1, 2, 3, 0};
  int n_g2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    #1;
    chk("reset_grant_id", grant_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_error", error, 0);
    chk("reset_m_rd_valid", m_rd_valid, 0);
    rst = 1'b1;

    // Test 1: single read from master 2
    set_rd(2, 32'h1000, 1);
    step();
    #1;
    chk("t1_rd_valid_after_1clk", m_rd_valid, 1);
    chk("t1_rd_addr", m_rd_addr, 32'h1000);
    chk("t1_grant_id", grant_id, 2);
    wait_fin(20);
    #1;
    chk("t1_finish_demux", s_rd_burst_finish, 4'b0100);
    wait_idle(50);

    // Test 2: all four masters write, master 0 re-requests once
    do_reset();
    log_id.delete(); log_rd.delete(); min_gap = 999;
    for (int i = 0; i < N; i++) begin
      s_wr_data[i*DW +: DW] = c_pat[i];
      set_wr(i, 32'h2000 + 32'(i) * 32'h100, 2);
    end
`ifdef MEM_ARB_PRIORITY_EN
    n_g2 = 4;
`else
    n_g2 = 5;
    rearm_wr = 4'b0001;
`endif
    for (int g = 0; g < n_g2; g++) begin
      wait_grant(30);
      #1;
      chk("t2_grant_order", grant_id, c_ord2[g]);
      chk("t2_wr_data", m_wr_data, c_pat[c_ord2[g]]);
      if (g == n_g2 - 1) rearm_wr = '0;
      wait_fin(30);
      step();
    end
    wait_idle(100);
    chk("t2_grant_count", log_id.size(), n_g2);
    chk("t2_min_finish_to_valid", min_gap, 3);

    // Test 3: master 1 rd+wr, master 3 wr
    log_id.delete(); log_rd.delete();
    set_rd(1, 32'h3000, 2);
    set_wr(1, 32'h3100, 1);
    set_wr(3, 32'h3300, 2);
    wait_idle(200);
    chk("t3_count", log_id.size(), 3);
    if (log_id.size() == 3) begin
      chk("t3_first_id", log_id[0], 1);  chk("t3_first_rd", log_rd[0], 1);
      chk("t3_second_id", log_id[1], 3); chk("t3_second_rd", log_rd[1], 0);
      chk("t3_third_id", log_id[2], 1);  chk("t3_third_rd", log_rd[2], 0);
    end

    // Test 4: master 1 drops read valid mid-burst
    chk("t4_error_before", error, 0);
    set_rd(1, 32'h4000, 4);
    wait_grant(20);
    step(); step();
    s_rd_valid[1] = 1'b0;
    step();
    #1;
    chk("t4_error_set", error, 1);
    wait_fin(20);
    #1;
    chk("t4_burst_completes", s_rd_burst_finish, 4'b0010);
    wait_idle(50);
    set_wr(2, 32'h4200, 1);
    wait_grant(20);
    #1;
    chk("t4_next_grant", grant_id, 2);
    wait_idle(50);
    chk("t4_error_sticky", error, 1);

    // Test 5: reset in the middle of a write burst
    set_wr(2, 32'h5000, 5);
    wait_grant(20);
    step(); step();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("t5_wr_valid", m_wr_valid, 0);
    chk("t5_wr_addr", m_wr_addr, 0);
    chk("t5_wr_len", m_wr_burst_len, 0);
    chk("t5_wr_data", m_wr_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_error", error, 0);
    step(); step();
    set_rd(3, 32'h5300, 1);
    set_rd(0, 32'h5000, 1);
    rst = 1'b1;
    step();
    #1;
    chk("t5_first_winner", grant_id, 0);
    chk("t5_first_rd_valid", m_rd_valid, 1);
    wait_idle(100);

    // Test 6: master 0 keeps re-requesting reads while 1..3 wait to write
    log_id.delete(); log_rd.delete();
    set_rd(0, 32'h6000, 2);
    rearm_rd = 4'b0001;
    for (int i = 1; i < N; i++) set_wr(i, 32'h6000 + 32'(i) * 32'h100, 1);
    wait_idle(400);
    begin
`ifdef MEM_ARB_PRIORITY_EN
      int exp6 [6] = '{0, 0, 0, 1, 2, 3};
      chk("t6_count", log_id.size(), 6);
`else
      int exp6 [5] = '{0, 1, 2, 3, 0};
      chk("t6_count", log_id.size(), 5);
`endif
      for (int i = 0; i < $size(exp6); i++)
        if (i < log_id.size()) chk("t6_order", log_id[i], exp6[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
